// File: rtl/servile_mux_pkg.sv
// Shared bus widths and address-decode constants for the servile data-bus splitter.
package servile_mux_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    // Decode field: the top two address bits choose the target region.
    localparam int unsigned DEC_MSB = 31;
    localparam int unsigned DEC_LSB = 30;

    // Region code that routes to the internal memory; every other code goes external.
    localparam logic [1:0] MEM_REGION = 2'b00;

    // True when the byte address falls outside the memory region.
    function automatic logic is_ext_region(input logic [WB_ADR_W-1:0] adr);
        return (adr[DEC_MSB:DEC_LSB] != MEM_REGION);
    endfunction

endpackage

// File: rtl/servile_mux.sv
// Wishbone splitter between the servile CPU data bus and two targets (mem, ext).
// Routing is purely combinational; clock and reset only drive the optional
// simulation signature/halt monitor.
module servile_mux
    import servile_mux_pkg::*;
#(
    parameter int unsigned  SIM          = 0,
    parameter logic [31:0]  SIM_SIG_ADR  = 32'h8000_0000,
    parameter logic [31:0]  SIM_HALT_ADR = 32'h9000_0000
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic [WB_ADR_W-1:0] i_wb_cpu_adr,
    input  logic [WB_DAT_W-1:0] i_wb_cpu_dat,
    input  logic [WB_SEL_W-1:0] i_wb_cpu_sel,
    input  logic                i_wb_cpu_we,
    input  logic                i_wb_cpu_stb,
    output logic [WB_DAT_W-1:0] o_wb_cpu_rdt,
    output logic                o_wb_cpu_ack,

    output logic [WB_ADR_W-1:0] o_wb_mem_adr,
    output logic [WB_DAT_W-1:0] o_wb_mem_dat,
    output logic [WB_SEL_W-1:0] o_wb_mem_sel,
    output logic                o_wb_mem_we,
    output logic                o_wb_mem_stb,
    input  logic [WB_DAT_W-1:0] i_wb_mem_rdt,
    input  logic                i_wb_mem_ack,

    output logic [WB_ADR_W-1:0] o_wb_ext_adr,
    output logic [WB_DAT_W-1:0] o_wb_ext_dat,
    output logic [WB_SEL_W-1:0] o_wb_ext_sel,
    output logic                o_wb_ext_we,
    output logic                o_wb_ext_stb,
    input  logic [WB_DAT_W-1:0] i_wb_ext_rdt,
    input  logic                i_wb_ext_ack
);

    logic sel_ext_s;

    // Decode the target from the current address; follows the address every cycle.
    always_comb begin
        sel_ext_s = is_ext_region(i_wb_cpu_adr);
    end

    // Forward request fields to both targets and steer strobe, read data and ack.
    always_comb begin
        o_wb_mem_adr = i_wb_cpu_adr;
        o_wb_mem_dat = i_wb_cpu_dat;
        o_wb_mem_sel = i_wb_cpu_sel;
        o_wb_mem_we  = i_wb_cpu_we;
        o_wb_ext_adr = i_wb_cpu_adr;
        o_wb_ext_dat = i_wb_cpu_dat;
        o_wb_ext_sel = i_wb_cpu_sel;
        o_wb_ext_we  = i_wb_cpu_we;

        // Only the selected target ever sees a strobe, so at most one is high.
        o_wb_mem_stb = i_wb_cpu_stb & ~sel_ext_s;
        o_wb_ext_stb = i_wb_cpu_stb &  sel_ext_s;

        // Ack and read data from the unselected target are ignored.
        if (sel_ext_s) begin
            o_wb_cpu_rdt = i_wb_ext_rdt;
            o_wb_cpu_ack = i_wb_ext_ack;
        end else begin
            o_wb_cpu_rdt = i_wb_mem_rdt;
            o_wb_cpu_ack = i_wb_mem_ack;
        end
    end

    generate
        if (SIM != 0) begin : g_sim_monitor
            logic                sig_hit_d;
            logic                sig_hit_q;
            logic [WB_DAT_W-1:0] sig_dat_d;
            logic [WB_DAT_W-1:0] sig_dat_q;
            logic                halt_d;
            logic                halt_q;

            // Detect completed writes to the signature and halt addresses.
            always_comb begin
                sig_hit_d = i_wb_cpu_stb & i_wb_cpu_we & o_wb_cpu_ack &
                            (i_wb_cpu_adr == SIM_SIG_ADR);
                halt_d    = i_wb_cpu_stb & i_wb_cpu_we & o_wb_cpu_ack &
                            (i_wb_cpu_adr == SIM_HALT_ADR);
                sig_dat_d = i_wb_cpu_dat;
            end

            // Register monitor hits, log signature words and stop on a halt write.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sig_hit_q <= 1'b0;
                    sig_dat_q <= {WB_DAT_W{1'b0}};
                    halt_q    <= 1'b0;
                end else begin
                    if (sig_hit_q) begin
                        $display("%08x", sig_dat_q);
                    end
                    if (halt_q) begin
                        $finish;
                    end
                    sig_hit_q <= sig_hit_d;
                    sig_dat_q <= sig_dat_d;
                    halt_q    <= halt_d;
                end
            end
        end else begin : g_no_monitor
            // Clock and reset have no function without the monitor.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = i_clk ^ i_rst;
        end
    endgenerate

endmodule

// File: tb/tb_servile_mux.sv
// Self-checking bench for servile_mux: directed literal cases plus randomized
// traffic compared every cycle against an address-range model.
`timescale 1ns/1ps
module tb_servile_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_adr = 32'h0, cpu_dat = 32'h0, cpu_rdt;
    logic [3:0]  cpu_sel = 4'h0;
    logic        cpu_we = 1'b0, cpu_stb = 1'b0, cpu_ack;
    logic [31:0] mem_adr, mem_dat, mem_rdt = 32'h0;
    logic [3:0]  mem_sel;
    logic        mem_we, mem_stb, mem_ack = 1'b0;
    logic [31:0] ext_adr, ext_dat, ext_rdt = 32'h0;
    logic [3:0]  ext_sel;
    logic        ext_we, ext_stb, ext_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    servile_mux dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
        .i_wb_cpu_we(cpu_we), .i_wb_cpu_stb(cpu_stb),
        .o_wb_cpu_rdt(cpu_rdt), .o_wb_cpu_ack(cpu_ack),
        .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
        .o_wb_mem_we(mem_we), .o_wb_mem_stb(mem_stb),
        .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
        .o_wb_ext_adr(ext_adr), .o_wb_ext_dat(ext_dat), .o_wb_ext_sel(ext_sel),
        .o_wb_ext_we(ext_we), .o_wb_ext_stb(ext_stb),
        .i_wb_ext_rdt(ext_rdt), .i_wb_ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: anything at or above 1 GiB is external; request fields go everywhere.
    always @(negedge clk) begin : cmp_blk
        logic ext;
        if (cmp_en) begin
            ext = (cpu_adr >= 32'h4000_0000);
            chk("m_mem_adr", mem_adr, cpu_adr);
            chk("m_ext_adr", ext_adr, cpu_adr);
            chk("m_mem_dat", mem_dat, cpu_dat);
            chk("m_ext_dat", ext_dat, cpu_dat);
            chk("m_mem_sel", {28'h0, mem_sel}, {28'h0, cpu_sel});
            chk("m_ext_sel", {28'h0, ext_sel}, {28'h0, cpu_sel});
            chk("m_mem_we",  {31'h0, mem_we}, {31'h0, cpu_we});
            chk("m_ext_we",  {31'h0, ext_we}, {31'h0, cpu_we});
            chk("m_mem_stb", {31'h0, mem_stb}, {31'h0, (cpu_stb && !ext)});
            chk("m_ext_stb", {31'h0, ext_stb}, {31'h0, (cpu_stb && ext)});
            chk("m_cpu_rdt", cpu_rdt, ext ? ext_rdt : mem_rdt);
            chk("m_cpu_ack", {31'h0, cpu_ack}, {31'h0, (ext ? ext_ack : mem_ack)});
        end
    end

    task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input logic stb, input logic mack, input logic eack);
        @(posedge clk);
        #1;
        cpu_adr = adr; cpu_dat = dat; cpu_sel = sel;
        cpu_we = we; cpu_stb = stb; mem_ack = mack; ext_ack = eack;
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        drive(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_stb", {31'h0, mem_stb}, 32'h0);
        chk("rst_ext_stb", {31'h0, ext_stb}, 32'h0);
        chk("rst_cpu_ack", {31'h0, cpu_ack}, 32'h0);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        // Mem write, then ack in the same cycle
        drive(32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("mw_mem_stb", {31'h0, mem_stb}, 32'h1);
        chk("mw_ext_stb", {31'h0, ext_stb}, 32'h0);
        chk("mw_mem_adr", mem_adr, 32'h0000_1000);
        chk("mw_mem_dat", mem_dat, 32'h1234_5678);
        chk("mw_ack_pre", {31'h0, cpu_ack}, 32'h0);
        drive(32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("mw_cpu_ack", {31'h0, cpu_ack}, 32'h1);

        // Ext write
        drive(32'hC000_0000, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("ew_ext_stb", {31'h0, ext_stb}, 32'h1);
        chk("ew_mem_stb", {31'h0, mem_stb}, 32'h0);
        chk("ew_ext_dat", ext_dat, 32'hA5A5_A5A5);
        drive(32'hC000_0000, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("ew_cpu_ack", {31'h0, cpu_ack}, 32'h1);

        // Read-data steering
        mem_rdt = 32'hFFEE_DDCC;
        ext_rdt = 32'hAABB_CCDD;
        drive(32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_mem", cpu_rdt, 32'hFFEE_DDCC);
        drive(32'h4000_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rd_ext", cpu_rdt, 32'hAABB_CCDD);

        // Stray ack from the unselected target
        drive(32'h0000_1000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("stray_ack", {31'h0, cpu_ack}, 32'h0);

        // Decode boundaries
        drive(32'h3FFF_FFFC, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bd_3fff_mem", {31'h0, mem_stb}, 32'h1);
        drive(32'h4000_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bd_4000_ext", {31'h0, ext_stb}, 32'h1);
        drive(32'h8000_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bd_8000_ext", {31'h0, ext_stb}, 32'h1);

        // Stb low: no strobes, ack still follows the selected target
        drive(32'hC000_0004, 32'h0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("idle_ext_stb", {31'h0, ext_stb}, 32'h0);
        chk("idle_ack", {31'h0, cpu_ack}, 32'h1);

        // Randomized traffic checked by the model process
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h3FFF_FFFC;
                1: a = 32'h4000_0000;
                2: a = {2'b00, a[29:0]};
                default: a = a;
            endcase
            mem_rdt = $urandom;
            ext_rdt = $urandom;
            drive(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            if (i % 50 == 0) begin
                rst = ~rst;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
